// File: rtl/seq_signed_multiplier.sv
// Iterative shift-add signed multiplier with start/done handshake, full-width exact product.
// Latency: done pulses k+2 edges after the start-sampling edge (k = B_WIDTH, or data-dependent when early termination is built in).
// Backpressure: none; start is only honoured while idle, and requests made while busy are dropped.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   start               request, sampled only in IDLE together with the operands
//   multiplicand        signed operand a (A_WIDTH bits)
//   multiplier          signed operand b (B_WIDTH bits)
//   product             signed a*b (A_WIDTH+B_WIDTH bits), registered, holds until next completion
//   busy                high whenever the engine is not idle
//   done                one-cycle pulse when product updates
//
// Build option: define MULT_EARLY_TERM_EN to leave COMPUTE as soon as the remaining
// multiplier magnitude is zero (after at least one iteration). Results are identical.
module seq_signed_multiplier #(
  parameter int A_WIDTH = 32,
  parameter int B_WIDTH = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [A_WIDTH-1:0]         multiplicand,
  input  logic [B_WIDTH-1:0]         multiplier,
  output logic [A_WIDTH+B_WIDTH-1:0] product,
  output logic                       busy,
  output logic                       done
);

  localparam int P_WIDTH   = A_WIDTH + B_WIDTH;
  localparam int CNT_WIDTH = $clog2(B_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE_ST = 2'd2
  } state_t;

  state_t               state;
  logic [P_WIDTH-1:0]   acc;
  logic [P_WIDTH-1:0]   mcand;
  logic [B_WIDTH-1:0]   mag_b;
  logic [CNT_WIDTH-1:0] iter_cnt;
  logic                 sign;

  // Magnitudes as unsigned values: negating the most-negative input yields
  // the same bit pattern, which read as unsigned is exactly 2^(W-1).
  logic [A_WIDTH-1:0] mag_a_in;
  logic [B_WIDTH-1:0] mag_b_in;
  assign mag_a_in = multiplicand[A_WIDTH-1] ? -multiplicand : multiplicand;
  assign mag_b_in = multiplier[B_WIDTH-1]   ? -multiplier   : multiplier;

  // Exit is evaluated at the top of each COMPUTE cycle, before any iteration,
  // so the cycle that decides to leave does not modify the datapath.
  logic compute_exit;
`ifdef MULT_EARLY_TERM_EN
  // At least one iteration always runs, so a zero multiplier still takes k=1.
  assign compute_exit = (iter_cnt != '0) && (mag_b == '0);
`else
  assign compute_exit = (iter_cnt == CNT_WIDTH'(B_WIDTH));
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      mcand    <= '0;
      mag_b    <= '0;
      iter_cnt <= '0;
      sign     <= 1'b0;
      product  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mag_b    <= mag_b_in;
            mcand    <= P_WIDTH'(mag_a_in);
            acc      <= '0;
            sign     <= multiplicand[A_WIDTH-1] ^ multiplier[B_WIDTH-1];
            iter_cnt <= '0;
            busy     <= 1'b1;
            state    <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (compute_exit) begin
            state <= DONE_ST;
          end else begin
            if (mag_b[0]) begin
              acc <= acc + mcand;
            end
            mcand    <= mcand << 1;
            mag_b    <= mag_b >> 1;
            iter_cnt <= iter_cnt + CNT_WIDTH'(1);
          end
        end
        DONE_ST: begin
          // Negating a zero accumulator gives zero, so -0 cannot occur.
          product <= sign ? -acc : acc;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
